// File: rtl/litepcie_us_pkg.sv
// -----------------------------------------------------------------------------
// litepcie_us_pkg
//   Shared definitions for the UltraScale x4 (128-bit) PCIe adapters.
//   - RC descriptor field bit offsets (hard-IP Requester Completion format).
//   - PCIe completion Fmt/Type constants.
//   - RC adapter FSM state encoding.
//   - Helper that widens a dword keep mask into a byte keep mask.
// -----------------------------------------------------------------------------
package litepcie_us_pkg;

    // RC descriptor (first beat from the hard IP) field offsets.
    localparam int unsigned RC_LOWER_ADDR_LSB = 0;   // [11:0]
    localparam int unsigned RC_ERR_LSB        = 12;  // [15:12]
    localparam int unsigned RC_BYTE_CNT_LSB   = 16;  // [28:16]
    localparam int unsigned RC_LOCKED_BIT     = 29;
    localparam int unsigned RC_DW_CNT_LSB     = 32;  // [42:32]
    localparam int unsigned RC_STATUS_LSB     = 43;  // [45:43]
    localparam int unsigned RC_POISON_BIT     = 46;
    localparam int unsigned RC_REQ_ID_LSB     = 48;  // [63:48]
    localparam int unsigned RC_TAG_LSB        = 64;  // [71:64]
    localparam int unsigned RC_CPL_ID_LSB     = 72;  // [87:72]
    localparam int unsigned RC_TC_LSB         = 89;  // [91:89]
    localparam int unsigned RC_ATTR_LSB       = 92;  // [94:92]

    // RC sideband.
    localparam int unsigned RC_TUSER_WIDTH    = 75;
    localparam int unsigned RC_TUSER_DISC_BIT = 42;

    // Completion Fmt/Type.
    localparam logic [4:0] CPL            = 5'b01010;
    localparam logic [4:0] CPLLK          = 5'b01011;
    localparam logic [2:0] FMT_3DW_DATA   = 3'b010;
    localparam logic [2:0] FMT_3DW_NODATA = 3'b000;

    typedef enum logic [1:0] {
        S_HEAD = 2'd0,
        S_DATA = 2'd1,
        S_DROP = 2'd2
    } rc_state_e;

    // Each dword keep bit covers four bytes.
    function automatic logic [15:0] expand_dw_keep(input logic [3:0] dw_keep);
        logic [15:0] bkeep;
        bkeep = '0;
        for (int i = 0; i < 4; i++) begin
            bkeep[4*i +: 4] = {4{dw_keep[i]}};
        end
        return bkeep;
    endfunction

endpackage

// File: rtl/m_axis_rc_adapt_x4_if.sv
// -----------------------------------------------------------------------------
// m_axis_rc_adapt_x4_if
//   Bundles both streams of the RC adapter:
//   - hard-IP side : m_axis_rc_tdata/tkeep/tlast/tuser/tvalid -> tready
//   - core side    : m_axis_rc_tdata_a/tkeep_a/tlast_a/tvalid_a <- tready_a
//   modport slave  : the adapter's view.
//   modport master : the environment's view (hard IP source + core sink).
// -----------------------------------------------------------------------------
interface m_axis_rc_adapt_x4_if #(
    parameter int unsigned DATA_WIDTH  = 128,
    parameter int unsigned KEEP_WIDTH  = DATA_WIDTH / 32,
    parameter int unsigned BKEEP_WIDTH = DATA_WIDTH / 8
);
    // Hard-IP side.
    logic [DATA_WIDTH-1:0]  m_axis_rc_tdata;
    logic [KEEP_WIDTH-1:0]  m_axis_rc_tkeep;
    logic                   m_axis_rc_tlast;
    logic [74:0]            m_axis_rc_tuser;
    logic                   m_axis_rc_tvalid;
    logic                   m_axis_rc_tready;

    // Core side.
    logic [DATA_WIDTH-1:0]  m_axis_rc_tdata_a;
    logic [BKEEP_WIDTH-1:0] m_axis_rc_tkeep_a;
    logic                   m_axis_rc_tlast_a;
    logic                   m_axis_rc_tvalid_a;
    logic                   m_axis_rc_tready_a;

    modport slave (
        input  m_axis_rc_tdata,
        input  m_axis_rc_tkeep,
        input  m_axis_rc_tlast,
        input  m_axis_rc_tuser,
        input  m_axis_rc_tvalid,
        output m_axis_rc_tready,
        output m_axis_rc_tdata_a,
        output m_axis_rc_tkeep_a,
        output m_axis_rc_tlast_a,
        output m_axis_rc_tvalid_a,
        input  m_axis_rc_tready_a
    );

    modport master (
        output m_axis_rc_tdata,
        output m_axis_rc_tkeep,
        output m_axis_rc_tlast,
        output m_axis_rc_tuser,
        output m_axis_rc_tvalid,
        input  m_axis_rc_tready,
        input  m_axis_rc_tdata_a,
        input  m_axis_rc_tkeep_a,
        input  m_axis_rc_tlast_a,
        input  m_axis_rc_tvalid_a,
        output m_axis_rc_tready_a
    );

endinterface

// File: rtl/rc_skid_buf.sv
// -----------------------------------------------------------------------------
// rc_skid_buf
//   Two-entry registered ready/valid buffer (ring of two registers).
//   Output data comes straight from a storage register, so a beat pushed on
//   one edge is visible on the output right after that edge.
//   Ports:
//     clk_i, rst_i            clock, synchronous active-high reset
//     in_data_i/valid_i/ready_o   upstream handshake
//     out_data_o/valid_o/ready_i  downstream handshake
// -----------------------------------------------------------------------------
module rc_skid_buf #(
    parameter int unsigned DAT_B = 145
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [DAT_B-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [DAT_B-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);

    logic [DAT_B-1:0] mem_q [2];
    logic [DAT_B-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             push, pop;

    // A full buffer still accepts when the head drains in the same cycle;
    // the freed slot is the one being written.
    assign in_ready_o  = (cnt_q != 2'd2) || out_ready_i;
    assign out_valid_o = (cnt_q != 2'd0);
    assign out_data_o  = mem_q[rd_ptr_q];

    assign push = in_valid_i && in_ready_o;
    assign pop  = out_valid_o && out_ready_i;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/m_axis_rc_adapt_x4.sv
// -----------------------------------------------------------------------------
// m_axis_rc_adapt_x4
//   Converts UltraScale x4 (128-bit) Requester Completion beats (3-DW RC
//   descriptor + payload) into standard PCIe 3-DW Cpl/CplD TLP beats for the
//   LitePCIe depacketizer. A header/data FSM picks the first beat of each TLP
//   for remapping; a 2-entry skid buffer registers the output.
//
//   Ports:
//     user_clk, user_reset  clock, synchronous active-high reset
//     rc (slave modport)    hard-IP RC stream in, core TLP stream out
//     rc_err_cnt            dropped completion count (0 unless drop enabled)
//
//   Build option LITEPCIE_RC_ERR_DROP_EN: header beats with err != 0 or
//   discontinue are swallowed together with the rest of their TLP and counted
//   in rc_err_cnt. Without it, such TLPs are forwarded with EP set.
// -----------------------------------------------------------------------------
module m_axis_rc_adapt_x4
    import litepcie_us_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 128,  // only 128 is supported
    parameter int unsigned KEEP_WIDTH  = DATA_WIDTH / 32,
    parameter int unsigned BKEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                user_clk,
    input  logic                user_reset,
    m_axis_rc_adapt_x4_if.slave rc,
    output logic [15:0]         rc_err_cnt
);

    localparam int unsigned DAT_B = DATA_WIDTH + BKEEP_WIDTH + 1;

    rc_state_e state_q, state_d;

    logic [DATA_WIDTH-1:0] d;
    logic                  disc;
    logic                  hdr_err;
    logic                  in_ready;
    logic                  in_fire;
    logic                  push;
    logic                  skid_in_ready;
    logic [DAT_B-1:0]      skid_in_data;
    logic [DAT_B-1:0]      skid_out_data;
    logic                  skid_out_valid;
    logic [31:0]           hdr_dw0, hdr_dw1, hdr_dw2;
    logic [DATA_WIDTH-1:0] out_tdata;
    logic [BKEEP_WIDTH-1:0] out_tkeep;
    logic                  unused_tuser;

    assign d    = rc.m_axis_rc_tdata;
    assign disc = rc.m_axis_rc_tuser[RC_TUSER_DISC_BIT];
    assign unused_tuser = ^{rc.m_axis_rc_tuser[74:43], rc.m_axis_rc_tuser[41:0]};

    // Only meaningful on a header beat.
    assign hdr_err = (d[RC_ERR_LSB +: 4] != 4'h0) || disc;

    // ------------------------------------------------------------------
    // Input handshake. While dropping, beats bypass the skid entirely.
    // ------------------------------------------------------------------
`ifdef LITEPCIE_RC_ERR_DROP_EN
    assign in_ready = (state_q == S_DROP) ? 1'b1 : skid_in_ready;
`else
    assign in_ready = skid_in_ready;
`endif
    assign rc.m_axis_rc_tready = in_ready && !user_reset;
    assign in_fire = rc.m_axis_rc_tvalid && rc.m_axis_rc_tready;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
`ifdef LITEPCIE_RC_ERR_DROP_EN
    logic drop_hit;
`endif

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
`ifdef LITEPCIE_RC_ERR_DROP_EN
        drop_hit = 1'b0;
`endif
        unique case (state_q)
            S_HEAD: begin
                if (in_fire) begin
`ifdef LITEPCIE_RC_ERR_DROP_EN
                    if (hdr_err) begin
                        drop_hit = 1'b1;
                        if (!rc.m_axis_rc_tlast) state_d = S_DROP;
                    end else begin
                        push = 1'b1;
                        if (!rc.m_axis_rc_tlast) state_d = S_DATA;
                    end
`else
                    push = 1'b1;
                    if (!rc.m_axis_rc_tlast) state_d = S_DATA;
`endif
                end
            end
            S_DATA: begin
                if (in_fire) begin
                    push = 1'b1;
                    if (rc.m_axis_rc_tlast) state_d = S_HEAD;
                end
            end
`ifdef LITEPCIE_RC_ERR_DROP_EN
            S_DROP: begin
                if (in_fire && rc.m_axis_rc_tlast) state_d = S_HEAD;
            end
`endif
            default: state_d = S_HEAD;
        endcase
    end

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            state_q <= S_HEAD;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Header remap: RC descriptor -> Cpl/CplD DW0..DW2.
    // dw_cnt and byte_cnt are truncated, so 1024 -> 0 and 4096 -> 0.
    // ------------------------------------------------------------------
    always_comb begin
        hdr_dw0 = '0;
        hdr_dw0[31:29] = (d[RC_DW_CNT_LSB +: 11] != 11'd0) ? FMT_3DW_DATA : FMT_3DW_NODATA;
        hdr_dw0[28:24] = d[RC_LOCKED_BIT] ? CPLLK : CPL;
        hdr_dw0[22:20] = d[RC_TC_LSB +: 3];
        // Errored completions that are forwarded are marked poisoned.
        hdr_dw0[14]    = d[RC_POISON_BIT] | hdr_err;
        hdr_dw0[13:12] = d[RC_ATTR_LSB +: 2];
        hdr_dw0[9:0]   = d[RC_DW_CNT_LSB +: 10];

        hdr_dw1 = '0;
        hdr_dw1[31:16] = d[RC_CPL_ID_LSB +: 16];
        hdr_dw1[15:13] = d[RC_STATUS_LSB +: 3];
        hdr_dw1[11:0]  = d[RC_BYTE_CNT_LSB +: 12];

        hdr_dw2 = '0;
        hdr_dw2[31:16] = d[RC_REQ_ID_LSB +: 16];
        hdr_dw2[15:8]  = d[RC_TAG_LSB +: 8];
        hdr_dw2[6:0]   = d[RC_LOWER_ADDR_LSB +: 7];
    end

    // First payload dword already sits in [127:96] of the descriptor beat.
    assign out_tdata = (state_q == S_HEAD) ? {d[127:96], hdr_dw2, hdr_dw1, hdr_dw0} : d;
    assign out_tkeep = expand_dw_keep(rc.m_axis_rc_tkeep);

    assign skid_in_data = {rc.m_axis_rc_tlast, out_tkeep, out_tdata};

    rc_skid_buf #(
        .DAT_B (DAT_B)
    ) u_skid (
        .clk_i       (user_clk),
        .rst_i       (user_reset),
        .in_data_i   (skid_in_data),
        .in_valid_i  (push),
        .in_ready_o  (skid_in_ready),
        .out_data_o  (skid_out_data),
        .out_valid_o (skid_out_valid),
        .out_ready_i (rc.m_axis_rc_tready_a)
    );

    assign rc.m_axis_rc_tdata_a  = skid_out_data[DATA_WIDTH-1:0];
    assign rc.m_axis_rc_tkeep_a  = skid_out_data[DATA_WIDTH +: BKEEP_WIDTH];
    assign rc.m_axis_rc_tlast_a  = skid_out_data[DAT_B-1];
    assign rc.m_axis_rc_tvalid_a = skid_out_valid;

    // ------------------------------------------------------------------
    // Dropped-TLP counter (saturating).
    // ------------------------------------------------------------------
`ifdef LITEPCIE_RC_ERR_DROP_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (drop_hit && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            err_cnt_q <= 16'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign rc_err_cnt = err_cnt_q;
`else
    assign rc_err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_m_axis_rc_adapt_x4.sv
// -----------------------------------------------------------------------------
// tb_m_axis_rc_adapt_x4
//   Directed and randomized completions driven into the RC adapter; every
//   output beat is compared against a queue of beats predicted from the
//   completion fields. Also watches the ready/valid behaviour of the skid.
// -----------------------------------------------------------------------------
module tb_m_axis_rc_adapt_x4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] err_cnt;

    always #5 clk = ~clk;

    m_axis_rc_adapt_x4_if #(.DATA_WIDTH(128)) bus ();

    m_axis_rc_adapt_x4 #(.DATA_WIDTH(128)) dut (
        .user_clk   (clk),
        .user_reset (rst),
        .rc         (bus),
        .rc_err_cnt (err_cnt)
    );

    typedef struct {
        logic [127:0] data;
        logic [15:0]  keep;
        logic         last;
    } beat_t;

    typedef struct {
        logic [11:0] lower_addr;
        logic [3:0]  err;
        logic [12:0] byte_cnt;
        logic        locked;
        logic [10:0] dw_cnt;
        logic [2:0]  status;
        logic        poison;
        logic [15:0] req_id;
        logic [7:0]  tag;
        logic [15:0] cpl_id;
        logic [2:0]  tc;
        logic [2:0]  attr;
    } fields_t;

    int total = 0;
    int bad   = 0;

    beat_t exp_q[$];
    beat_t hdr_b, last_b;
    int    occ       = 0;
    bit    in_pkt    = 1'b0;
    bit    cur_has_exp = 1'b0;
    int    rmode     = 0;
    int    gap_pct   = 0;
    int    n_drop    = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] keep_bytes(input logic [3:0] k);
        logic [15:0] r = 16'h0;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) r = r | (16'hF << (4 * i));
        end
        return r;
    endfunction

    function automatic logic [95:0] ref_hdr(input fields_t f, input logic disc);
        logic [31:0] dw0, dw1, dw2;
        logic        ep;
        ep  = f.poison | disc | (f.err != 4'h0);
        dw0 = (f.dw_cnt != 11'd0 ? 32'd2 : 32'd0) << 29;
        dw0 = dw0 + ((f.locked ? 32'd11 : 32'd10) << 24);
        dw0 = dw0 + (32'(f.tc) << 20);
        dw0 = dw0 + (32'(ep) << 14);
        dw0 = dw0 + ((32'(f.attr) % 32'd4) << 12);
        dw0 = dw0 + (32'(f.dw_cnt) % 32'd1024);
        dw1 = (32'(f.cpl_id) << 16) + (32'(f.status) << 13) + (32'(f.byte_cnt) % 32'd4096);
        dw2 = (32'(f.req_id) << 16) + (32'(f.tag) << 8) + (32'(f.lower_addr) % 32'd128);
        return {dw2, dw1, dw0};
    endfunction

    // Hard-IP descriptor, reserved bits filled with noise.
    function automatic logic [127:0] make_desc(input fields_t f);
        logic [127:0] d;
        d = {$urandom, $urandom, $urandom, $urandom};
        d[11:0]  = f.lower_addr;
        d[15:12] = f.err;
        d[28:16] = f.byte_cnt;
        d[29]    = f.locked;
        d[42:32] = f.dw_cnt;
        d[45:43] = f.status;
        d[46]    = f.poison;
        d[63:48] = f.req_id;
        d[71:64] = f.tag;
        d[87:72] = f.cpl_id;
        d[91:89] = f.tc;
        d[94:92] = f.attr;
        return d;
    endfunction

    function automatic fields_t zero_fields();
        fields_t f;
        f.lower_addr = '0; f.err = '0; f.byte_cnt = '0; f.locked = 1'b0;
        f.dw_cnt = '0; f.status = '0; f.poison = 1'b0; f.req_id = '0;
        f.tag = '0; f.cpl_id = '0; f.tc = '0; f.attr = '0;
        return f;
    endfunction

    function automatic fields_t rand_fields();
        fields_t f;
        f.lower_addr = 12'($urandom);
        f.err        = 4'h0;
        f.byte_cnt   = 13'($urandom_range(0, 4096));
        f.locked     = 1'($urandom);
        f.dw_cnt     = 11'($urandom_range(0, 1024));
        f.status     = 3'($urandom);
        f.poison     = ($urandom_range(0, 7) == 0);
        f.req_id     = 16'($urandom);
        f.tag        = 8'($urandom);
        f.cpl_id     = 16'($urandom);
        f.tc         = 3'($urandom);
        f.attr       = 3'($urandom);
        return f;
    endfunction

    // ---------------- driver ----------------
    task automatic drive_beat(input logic [127:0] d, input logic [3:0] k, input logic last,
                              input logic disc, input beat_t e, input logic has_exp);
        logic [74:0] u;
        logic        acc;
        int          n;
        u = '0;
        u[42] = disc;
        bus.m_axis_rc_tdata  = d;
        bus.m_axis_rc_tkeep  = k;
        bus.m_axis_rc_tlast  = last;
        bus.m_axis_rc_tuser  = u;
        bus.m_axis_rc_tvalid = 1'b1;
        cur_has_exp = has_exp;
        n = 0;
        acc = 1'b0;
        do begin
            @(negedge clk);
            acc = bus.m_axis_rc_tready;
            if (acc && has_exp) exp_q.push_back(e);
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) chk("accept_timeout", 0, 1);
        bus.m_axis_rc_tvalid = 1'b0;
    endtask

    task automatic send_tlp(input fields_t f, input int nb, input logic [3:0] lastk,
                            input logic disc);
        logic [127:0] d;
        logic [3:0]   k;
        logic         last;
        logic         dropped;
        beat_t        e;
        dropped = 1'b0;
`ifdef LITEPCIE_RC_ERR_DROP_EN
        dropped = (f.err != 4'h0) || disc;
        if (dropped && n_drop < 65535) n_drop++;
`endif
        for (int b = 0; b < nb; b++) begin
            last = (b == nb - 1);
            k    = last ? lastk : 4'hF;
            if (b == 0) begin
                d = make_desc(f);
                e.data = {d[127:96], ref_hdr(f, disc)};
            end else begin
                d = {$urandom, $urandom, $urandom, $urandom};
                e.data = d;
            end
            e.keep = keep_bytes(k);
            e.last = last;
            drive_beat(d, k, last, disc, e, !dropped);
            if ($urandom_range(0, 99) < gap_pct) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- core-side ready ----------------
    initial begin
        int pat_i = 0;
        bus.m_axis_rc_tready_a = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                1:       bus.m_axis_rc_tready_a = 1'($urandom);
                2:       bus.m_axis_rc_tready_a = (pat_i % 3 == 0);
                default: bus.m_axis_rc_tready_a = 1'b1;
            endcase
            pat_i++;
        end
    end

    // ---------------- monitor ----------------
    logic  m_acc, m_pop, m_exp_rdy;
    beat_t m_e;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            occ    = 0;
            in_pkt = 1'b0;
        end else begin
            m_acc = bus.m_axis_rc_tvalid && bus.m_axis_rc_tready;
            m_pop = bus.m_axis_rc_tvalid_a && bus.m_axis_rc_tready_a;
            m_exp_rdy = (occ < 2) || bus.m_axis_rc_tready_a;
`ifdef LITEPCIE_RC_ERR_DROP_EN
            if (m_exp_rdy) chk("tready", bus.m_axis_rc_tready, 1);
`else
            chk("tready", bus.m_axis_rc_tready, m_exp_rdy);
`endif
            chk("tvalid_a", bus.m_axis_rc_tvalid_a, occ > 0);
            if (m_pop) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("tdata_a", bus.m_axis_rc_tdata_a, m_e.data);
                    chk("tkeep_a", bus.m_axis_rc_tkeep_a, m_e.keep);
                    chk("tlast_a", bus.m_axis_rc_tlast_a, m_e.last);
                end
                last_b.data = bus.m_axis_rc_tdata_a;
                last_b.keep = bus.m_axis_rc_tkeep_a;
                last_b.last = bus.m_axis_rc_tlast_a;
                if (!in_pkt) hdr_b = last_b;
                in_pkt = !bus.m_axis_rc_tlast_a;
            end
            occ = occ + ((m_acc && cur_has_exp) ? 1 : 0) - (m_pop ? 1 : 0);
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        fields_t      f;
        beat_t        e;
        logic [127:0] d;
        logic [3:0]   lk;

        bus.m_axis_rc_tdata  = '0;
        bus.m_axis_rc_tkeep  = '0;
        bus.m_axis_rc_tlast  = 1'b0;
        bus.m_axis_rc_tuser  = '0;
        bus.m_axis_rc_tvalid = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid_a", bus.m_axis_rc_tvalid_a, 0);
        chk("rst_tdata_a", bus.m_axis_rc_tdata_a, 0);
        chk("rst_tkeep_a", bus.m_axis_rc_tkeep_a, 0);
        chk("rst_tlast_a", bus.m_axis_rc_tlast_a, 0);
        chk("rst_err_cnt", err_cnt, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // CplD, 1 DW, single beat.
        f = zero_fields();
        f.dw_cnt = 11'd1; f.tag = 8'h2A; f.byte_cnt = 13'd4; f.lower_addr = 12'h010;
        send_tlp(f, 1, 4'hF, 1'b0);
        chk("t1_latency", bus.m_axis_rc_tvalid_a, 1);
        wait_drain();
        chk("t1_dw0", hdr_b.data[31:0], 32'h4A000001);
        chk("t1_tag", hdr_b.data[79:72], 8'h2A);
        chk("t1_laddr", hdr_b.data[70:64], 7'h10);
        chk("t1_keep", hdr_b.keep, 16'hFFFF);
        chk("t1_last", hdr_b.last, 1);

        // CplD, 8 DW, three beats.
        f = rand_fields();
        f.dw_cnt = 11'd8; f.byte_cnt = 13'd32;
        send_tlp(f, 3, 4'b0111, 1'b0);
        wait_drain();
        chk("t2_last_keep", last_b.keep, 16'h0FFF);
        chk("t2_fmt", hdr_b.data[31:29], 3'b010);

        // Cpl without data, UR status.
        f = rand_fields();
        f.dw_cnt = 11'd0; f.status = 3'b001;
        send_tlp(f, 1, 4'b0111, 1'b0);
        wait_drain();
        chk("t3_fmt", hdr_b.data[31:29], 3'b000);
        chk("t3_status", hdr_b.data[47:45], 3'b001);
        chk("t3_keep", hdr_b.keep, 16'h0FFF);

        // Back-to-back 4-beat TLPs, ready pattern 1,0,0.
        rmode = 2;
        for (int i = 0; i < 6; i++) begin
            send_tlp(rand_fields(), 4, 4'hF, 1'b0);
        end
        wait_drain();
        rmode = 0;

        // Completion error in the descriptor.
        f = rand_fields();
        f.err = 4'h1;
        send_tlp(f, 3, 4'hF, 1'b0);
        wait_drain();
`ifdef LITEPCIE_RC_ERR_DROP_EN
        chk("t5_err_cnt", err_cnt, n_drop);
`else
        chk("t5_ep", hdr_b.data[14], 1);
        chk("t5_err_cnt", err_cnt, 0);
`endif

        // Reset on beat 2 of a 4-beat TLP.
        f = rand_fields();
        d = make_desc(f);
        e.data = {d[127:96], ref_hdr(f, 1'b0)};
        e.keep = 16'hFFFF;
        e.last = 1'b0;
        drive_beat(d, 4'hF, 1'b0, 1'b0, e, 1'b1);
        bus.m_axis_rc_tdata  = {$urandom, $urandom, $urandom, $urandom};
        bus.m_axis_rc_tlast  = 1'b0;
        bus.m_axis_rc_tvalid = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        bus.m_axis_rc_tvalid = 1'b0;
        chk("t6_rst_tvalid_a", bus.m_axis_rc_tvalid_a, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        f = rand_fields();
        send_tlp(f, 1, 4'hF, 1'b0);
        wait_drain();
        chk("t6_hdr", hdr_b.data[95:0], ref_hdr(f, 1'b0));
        chk("t6_last", hdr_b.last, 1);

        // Random traffic with random backpressure and gaps.
        rmode   = 1;
        gap_pct = 25;
        for (int i = 0; i < 40; i++) begin
            f = rand_fields();
            case ($urandom_range(0, 3))
                0:       lk = 4'b0001;
                1:       lk = 4'b0011;
                2:       lk = 4'b0111;
                default: lk = 4'b1111;
            endcase
            send_tlp(f, $urandom_range(1, 5), lk, ($urandom_range(0, 9) == 0));
        end
        wait_drain();
`ifdef LITEPCIE_RC_ERR_DROP_EN
        chk("final_err_cnt", err_cnt, n_drop);
`endif
        chk("final_occ", occ, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
